// File: rtl/fsqrt_root_iter_if.sv
// Start/done handshake bundle between the normalizer side and the
// restoring square-root core.
interface fsqrt_root_iter_if;
   logic        start;
   logic [23:0] d_in;
   logic [4:0]  sa_in;
   logic        busy;
   logic        done;
   logic [23:0] q;
   logic        rem_nz;
   logic [4:0]  sa_out;

   modport master (
      output start, d_in, sa_in,
      input  busy, done, q, rem_nz, sa_out
   );

   modport slave (
      input  start, d_in, sa_in,
      output busy, done, q, rem_nz, sa_out
   );
endinterface

// File: rtl/fsqrt_root_iter.sv
// Radix-2 restoring square root of {d_in, 24'b0}, one root bit per clock,
// with a sticky remainder flag and the shift amount carried through.
module fsqrt_root_iter (
   input  logic             clk,
   input  logic             rst,
   fsqrt_root_iter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state;
   state_t      state_next;
   logic [47:0] rad;
   logic [25:0] r;
   logic [23:0] root;
   logic [4:0]  cnt;
   logic [4:0]  sa_hold;
   logic [23:0] q_reg;
   logic        rem_nz_reg;
   logic [4:0]  sa_out_reg;

   logic        accept;
   logic        last_iter;
   logic [25:0] r_shift;
   logic [25:0] trial;
   logic [25:0] diff;
   logic        borrow;
   logic [25:0] r_next;
   logic [23:0] root_next;

   assign accept    = ((state == IDLE) || (state == DONE)) && bus.start;
   assign last_iter = (state == CALC) && (cnt == 5'd0);

   // The remainder never exceeds 2*root, so r[25:24] stay zero before each shift.
   logic unused_r_msbs;
   assign unused_r_msbs = |r[25:24];

   // One shared subtractor: its borrow-out is the compare result.
   always_comb begin
      r_shift          = {r[23:0], rad[47:46]};
      trial            = {root, 2'b01};
      {borrow, diff}   = {1'b0, r_shift} - {1'b0, trial};
      r_next           = borrow ? r_shift : diff;
      root_next        = {root[22:0], ~borrow};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = CALC;
         CALC:    if (cnt == 5'd0) state_next = DONE;
         DONE:    state_next = bus.start ? CALC : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Results are published only on the final iteration and held until the next one.
   always_ff @(posedge clk) begin
      if (rst) begin
         rad        <= '0;
         r          <= '0;
         root       <= '0;
         cnt        <= '0;
         sa_hold    <= '0;
         q_reg      <= '0;
         rem_nz_reg <= 1'b0;
         sa_out_reg <= '0;
      end else if (accept) begin
         rad     <= {bus.d_in, 24'b0};
         r       <= '0;
         root    <= '0;
         cnt     <= 5'd23;
         sa_hold <= bus.sa_in;
      end else if (state == CALC) begin
         rad  <= {rad[45:0], 2'b00};
         r    <= r_next;
         root <= root_next;
         if (cnt != 5'd0) begin
            cnt <= cnt - 5'd1;
         end
         if (last_iter) begin
            q_reg      <= root_next;
            rem_nz_reg <= |r_next;
            sa_out_reg <= sa_hold;
         end
      end
   end

   assign bus.busy   = (state == CALC);
   assign bus.done   = (state == DONE);
   assign bus.q      = q_reg;
   assign bus.rem_nz = rem_nz_reg;
   assign bus.sa_out = sa_out_reg;

endmodule

// File: doc/fsqrt_root_iter.md
# fsqrt_root_iter

Multicycle radix-2 restoring square-root core for the single-precision square-root path. It sits directly downstream of the even-bit normalizer. It accepts the normalized 24-bit fraction (MSB pair `1x` or `01`) and the even shift amount, then produces a 24-bit root fraction, a sticky remainder flag for rounding, and the shift amount carried alongside. It computes one root bit per clock under a start/done handshake.

## Interface
- No parameters; all widths fixed by the single-precision format.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only when `busy`=0
- `d_in`  in  24  normalized fraction from the normalizer
- `sa_in`  in  5  even shift amount from the normalizer
- `busy`  out  1  high while iterating; `start` ignored
- `done`  out  1  one-cycle pulse: `q`, `rem_nz`, `sa_out` valid
- `q`  out  24  root, floor(sqrt({d_in, 24'b0}))
- `rem_nz`  out  1  1 when remainder ≠ 0 (sticky)
- `sa_out`  out  5  `sa_in` captured at accept

## Operation
- Radicand R = {d_in, 24'b0}, 48 bits. Root q = floor(sqrt(R)). Remainder = R − q², at most 2q, so 25 bits.
- Normalized nonzero `d_in` (≥ 24'h400000) guarantees q[23]=1. Other inputs are legal and give the exact floor root: `d_in`=0 gives q=0, `rem_nz`=0.
- Internal registers:
  - radicand shift register: 48 bits
  - partial remainder `r`: 26 bits, unsigned
  - partial root: 24 bits
  - down-counter `cnt`: 5 bits
  - state
- Each iteration, MSB pair first:
  - r' = {r[23:0], next two radicand bits}
  - trial = {root[23:0], 2'b01}, evaluated at 26 bits
  - if r' ≥ trial: r ← r' − trial, root ← {root[22:0], 1}
  - else: r ← r', root ← {root[22:0], 0}
- Width rule: intermediate values never exceed 26 bits, so no overflow or truncation is permitted.
- The subtract and compare share a single 26-bit subtractor; the borrow-out selects the result.
- State machine:
  - IDLE: `start` → capture `d_in`/`sa_in`, clear r and root, `cnt`←23, go to CALC.
  - CALC: one iteration per clock. When `cnt`=0, go to DONE; otherwise decrement `cnt`.
  - DONE: `done`=1. Go to IDLE, or to CALC if `start`=1 (back-to-back accept).
- `q`, `rem_nz`, `sa_out` are updated only on the CALC→DONE transition. They hold until the next CALC→DONE transition, including through IDLE and a following CALC.
- `rem_nz` = |r after the final iteration.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `q`=0, `rem_nz`=0, `sa_out`=0; internal registers 0.
- Latency: `start` accepted at edge E; iterations occur at edges E+1..E+24; `done`=1 during the cycle after edge E+24.
- Cycle spacing: `done` comes 24 cycles after accept. Initiation interval is 25 cycles, with back-to-back accept from DONE.
- `busy`=1 exactly in CALC (24 cycles). `start` with `busy`=1 is ignored; no queuing.
- `start` in IDLE or DONE is accepted, so `done` and accept may coincide in the same cycle.
- `rst` mid-CALC aborts the operation: the next cycle is IDLE, all outputs are 0, and no `done` is produced.
- `rst` together with `start` resolves as reset: nothing is accepted.
- `d_in` and `sa_in` need only be stable in the accept cycle.

## Test plan
- `d_in`=24'h400000, `sa_in`=5'd2 → after 24 cycles `done`; `q`=24'h800000, `rem_nz`=0, `sa_out`=2.
- `d_in`=24'h800000 → `q`=24'hB504F3, `rem_nz`=1. `d_in`=24'h900000 → `q`=24'hC00000, `rem_nz`=0.
- `d_in`=24'hFFFFFF → `q`=24'hFFFFFF, `rem_nz`=1 (remainder 24'hFFFFFF); checks the 26-bit width.
- Handshake and hold:
  - `start` pulsed repeatedly during CALC with different `d_in` → ignored; result matches the first operand.
  - `start` asserted in the DONE cycle → second result exactly 25 cycles after the first.
  - Outputs hold through idle cycles.
- Reset:
  - `rst` at iteration 10 → outputs 0, no `done`; a subsequent `start` gives a correct result.
  - Random sweep of 10k normalized `d_in` against a reference floor-sqrt model, including `d_in`=0.
